// File: rtl/sap2_prog_loader.sv
// Feeds a 12-bit word stream into the sap2_mini programming port: clear, write
// words to ascending addresses, clear again, then release the CPU to run.
`timescale 1ns/1ps
module sap2_prog_loader #(
  parameter int CLR_CYCLES  = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ld_start,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        cpu_clr,
  output logic        cpu_prog,
  output logic [7:0]  cpu_a,
  output logic [11:0] cpu_d,
  output logic        busy,
  output logic        run,
  output logic        err,
  output logic [8:0]  word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRECLR, S_WAIT, S_HOLD, S_POSTCLR, S_RUN, S_ERR
  } state_t;

  localparam int MAXC = (CLR_CYCLES > HOLD_CYCLES) ? CLR_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] CLR_END  = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_q;
  logic          full;

  // word_cnt==256 means every address is used; no further word may be taken.
  assign full     = word_cnt[8];
  assign in_ready = (state == S_WAIT) && !full;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last_q   <= 1'b0;
      cpu_clr  <= 1'b1;
      cpu_prog <= 1'b0;
      cpu_a    <= '0;
      cpu_d    <= '0;
      busy     <= 1'b0;
      run      <= 1'b0;
      err      <= 1'b0;
      word_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (ld_start) begin
            state    <= S_PRECLR;
            cnt      <= '0;
            cpu_clr  <= 1'b1;
            cpu_prog <= 1'b0;
            busy     <= 1'b1;
            run      <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
          end
        end
        S_PRECLR: begin
          if (cnt == CLR_END) begin
            state    <= S_WAIT;
            cnt      <= '0;
            cpu_clr  <= 1'b0;
            cpu_prog <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (in_valid && in_ready) begin
            state    <= S_HOLD;
            cnt      <= '0;
            cpu_a    <= word_cnt[7:0];
            cpu_d    <= in_data;
            word_cnt <= word_cnt + 9'd1;
            last_q   <= in_last;
          end else if (in_valid && full) begin
            state    <= S_ERR;
            err      <= 1'b1;
            busy     <= 1'b0;
            cpu_clr  <= 1'b1;
            cpu_prog <= 1'b0;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_END) begin
            cnt <= '0;
            if (last_q) begin
              state    <= S_POSTCLR;
              cpu_prog <= 1'b0;
              cpu_clr  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_POSTCLR: begin
          if (cnt == CLR_END) begin
            state   <= S_RUN;
            cnt     <= '0;
            cpu_clr <= 1'b0;
            busy    <= 1'b0;
            run     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap2_prog_loader.sv
// Randomized load sessions for sap2_prog_loader, checked against a transaction
// model: the k-th accepted word must appear at address k with its own data.
`timescale 1ns/1ps
module tb_sap2_prog_loader;
  localparam int CLR_CYCLES  = 2;
  localparam int HOLD_CYCLES = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        ld_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready, cpu_clr, cpu_prog, busy, run, err;
  logic [7:0]  cpu_a;
  logic [11:0] cpu_d;
  logic [8:0]  word_cnt;

  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] pm [256];

  sap2_prog_loader #(.CLR_CYCLES(CLR_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .clr(clr), .ld_start(ld_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .cpu_clr(cpu_clr), .cpu_prog(cpu_prog), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .busy(busy), .run(run), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset();
    chk("rst_clr", cpu_clr, 1);   chk("rst_prog", cpu_prog, 0);
    chk("rst_a", cpu_a, 0);       chk("rst_d", cpu_d, 0);
    chk("rst_busy", busy, 0);     chk("rst_run", run, 0);
    chk("rst_err", err, 0);       chk("rst_cnt", word_cnt, 0);
    chk("rst_rdy", in_ready, 0);
  endtask

  // One load session of n words from pm[]. Gaps of gmin..gmax idle cycles
  // precede each word; gmax==0 keeps in_valid high throughout. abort_at and
  // ldmid_at name the word whose HOLD gets a clr or a stray ld_start (-1: none).
  task automatic session(input int n, input bit use_last, input int gmin, input int gmax,
                         input int abort_at, input int ldmid_at);
    int w, g;
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("pre_busy", busy, 1); chk("pre_clr", cpu_clr, 1); chk("pre_prog", cpu_prog, 0);
    chk("pre_run", run, 0);   chk("pre_err", err, 0);     chk("pre_cnt", word_cnt, 0);
    repeat (CLR_CYCLES - 1) begin tick(); chk("pre_clr_len", cpu_clr, 1); end
    tick();
    chk("wait_clr", cpu_clr, 0); chk("wait_prog", cpu_prog, 1); chk("wait_busy", busy, 1);
    for (int i = 0; i < n; i++) begin
      g = (gmax == 0) ? 0 : $urandom_range(gmax, gmin);
      in_valid = 1'b0;
      repeat (g) begin tick(); chk("gap_rdy", in_ready, 1); end
      in_valid = 1'b1;
      in_data  = pm[i];
      in_last  = use_last && (i == n - 1);
      w = 0;
      while (!in_ready && w < 10) begin tick(); w++; end
      chk("rdy_timeout", in_ready, 1);
      tick();
      in_valid = (gmax == 0);
      in_data  = 12'($urandom);
      in_last  = 1'b0;
      chk("wr_a", cpu_a, i[7:0]);   chk("wr_d", cpu_d, pm[i]);
      chk("wr_prog", cpu_prog, 1);  chk("wr_cnt", word_cnt, i + 1);
      chk("hold_rdy", in_ready, 0);
      if (i == abort_at) begin
        clr = 1'b1; tick(); clr = 1'b0;
        in_valid = 1'b0;
        chk_reset();
        return;
      end
      if (i == ldmid_at) ld_start = 1'b1;
      repeat (HOLD_CYCLES - 1) begin
        tick(); ld_start = 1'b0;
        chk("hold_a", cpu_a, i[7:0]); chk("hold_d", cpu_d, pm[i]); chk("hold_prog", cpu_prog, 1);
      end
      tick(); ld_start = 1'b0;
      if (use_last && i == n - 1) begin
        chk("post_clr", cpu_clr, 1); chk("post_prog", cpu_prog, 0);
        chk("post_busy", busy, 1);   chk("post_a", cpu_a, i[7:0]);
        repeat (CLR_CYCLES - 1) begin tick(); chk("post_clr_len", cpu_clr, 1); end
        tick();
        chk("run", run, 1);           chk("run_busy", busy, 0);
        chk("run_clr", cpu_clr, 0);   chk("run_prog", cpu_prog, 0);
        chk("run_cnt", word_cnt, n);  chk("run_err", err, 0);
      end else begin
        chk("next_busy", busy, 1); chk("next_prog", cpu_prog, 1); chk("next_clr", cpu_clr, 0);
        chk("next_a", cpu_a, i[7:0]);
        chk("next_rdy", in_ready, (i + 1 < 256) ? 1 : 0);
      end
    end
    if (!use_last) begin
      in_valid = 1'b1;
      tick();
      chk("ovf_err", err, 1);      chk("ovf_clr", cpu_clr, 1);
      chk("ovf_busy", busy, 0);    chk("ovf_prog", cpu_prog, 0);
      chk("ovf_rdy", in_ready, 0); chk("ovf_cnt", word_cnt, 256);
      tick();
      chk("ovf_sticky", err, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pm[i] = 12'($urandom);
  endtask

  initial begin
    logic [11:0] prog11 [11];
    int n;
    prog11 = '{12'h007, 12'h108, 12'h109, 12'h20a, 12'hfe0, 12'hff0,
               12'hfff, 12'h001, 12'h002, 12'h003, 12'h004};
    tick(); tick();
    clr = 1'b0;
    chk_reset();
    tick();
    chk("idle_clr", cpu_clr, 1);

    for (int i = 0; i < 11; i++) pm[i] = prog11[i];
    session(11, 1'b1, 0, 0, -1, -1);
    session(11, 1'b1, 3, 3, -1, -1);   // starts from RUN: reload
    pm[0] = 12'hff0;
    session(1, 1'b1, 0, 0, -1, -1);

    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(20, 1);
      fill_random(n);
      session(n, 1'b1, 0, $urandom_range(4, 0), -1, $urandom_range(n - 1, 0));
    end

    fill_random(256);
    session(256, 1'b1, 0, 0, -1, -1);
    fill_random(256);
    session(256, 1'b0, 0, 0, -1, -1);
    fill_random(8);
    session(8, 1'b1, 0, 2, -1, -1);    // from ERR: err cleared, address 0

    fill_random(10);
    session(10, 1'b1, 0, 0, 5, -1);
    fill_random(7);
    session(7, 1'b1, 0, 1, -1, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
